// File: rtl/cpu_pkg.sv
// Definitions shared by the ID/EX/MEM/WB segments: datapath widths,
// the hardwired-zero register index and the register index type.
package cpu_pkg;

  localparam int DATA_W   = 32;
  localparam int ADDR_W   = 5;
  localparam int REG_ZERO = 0;

  typedef logic [ADDR_W-1:0] reg_idx_t;

endpackage

// File: rtl/reg_scoreboard.sv
// Per-register pending-write scoreboard: issues count up, commits count down,
// and reads of registers with writes still in flight raise a stall.
module reg_scoreboard #(
  parameter int ADDR_W = 5,
  parameter int CNT_W  = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wb_write_i,
  input  logic [ADDR_W-1:0] wb_addr_i,
  input  logic [ADDR_W-1:0] rd_addr_a_i,
  input  logic [ADDR_W-1:0] rd_addr_b_i,
  input  logic              use_a_i,
  input  logic              use_b_i,
  input  logic              issue_valid_i,
  input  logic              issue_write_i,
  input  logic [ADDR_W-1:0] issue_dst_i,
  output logic              stall_o,
  output logic              sb_err_o
);
  import cpu_pkg::*;

  localparam int                NREG     = 2**ADDR_W;
  localparam logic [CNT_W-1:0]  CNT_MAX  = '1;
  localparam logic [ADDR_W-1:0] ZERO_IDX = ADDR_W'(REG_ZERO);

  logic [CNT_W-1:0] cnt_q [NREG];
  logic [CNT_W-1:0] cnt_d [NREG];
  logic             sb_err_q, sb_err_d;

  logic             commitFire, issueFire;
  logic             decA, decB, busyA, busyB;
  logic [CNT_W-1:0] remA, remB;

  assign commitFire = wb_write_i && (wb_addr_i != ZERO_IDX);

  // A write retiring this cycle is bypassed to the reader, so it no longer counts.
  assign decA  = commitFire && (wb_addr_i == rd_addr_a_i);
  assign decB  = commitFire && (wb_addr_i == rd_addr_b_i);
  assign remA  = cnt_q[rd_addr_a_i] - CNT_W'(decA);
  assign remB  = cnt_q[rd_addr_b_i] - CNT_W'(decB);
  assign busyA = (rd_addr_a_i != ZERO_IDX) && (remA != '0);
  assign busyB = (rd_addr_b_i != ZERO_IDX) && (remB != '0);

  assign stall_o   = (use_a_i && busyA) || (use_b_i && busyB);
  assign issueFire = issue_valid_i && !stall_o && issue_write_i && (issue_dst_i != ZERO_IDX);
  assign sb_err_o  = sb_err_q;

  always_comb begin
    sb_err_d = sb_err_q;
    for (int i = 0; i < NREG; i++) begin
      cnt_d[i] = cnt_q[i];
      case ({issueFire && (issue_dst_i == ADDR_W'(i)), commitFire && (wb_addr_i == ADDR_W'(i))})
        2'b10: begin
          if (cnt_q[i] == CNT_MAX) sb_err_d = 1'b1;
          else                     cnt_d[i] = cnt_q[i] + CNT_W'(1);
        end
        2'b01: begin
          if (cnt_q[i] == '0) sb_err_d = 1'b1;
          else                cnt_d[i] = cnt_q[i] - CNT_W'(1);
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NREG; i++) cnt_q[i] <= '0;
      sb_err_q <= 1'b0;
    end else begin
      cnt_q    <= cnt_d;
      sb_err_q <= sb_err_d;
    end
  end

endmodule

// File: rtl/wb_regfile.sv
// General-purpose register file at the end of the write-back segment:
// commits WB results, serves two bypassed read ports, and tracks pending writes.
module wb_regfile #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5,
  parameter int CNT_W  = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wb_write,
  input  logic [ADDR_W-1:0] wb_addr,
  input  logic [DATA_W-1:0] wb_data,
  input  logic [ADDR_W-1:0] rd_addr_a,
  input  logic [ADDR_W-1:0] rd_addr_b,
  input  logic              use_a,
  input  logic              use_b,
  output logic [DATA_W-1:0] rd_data_a,
  output logic [DATA_W-1:0] rd_data_b,
  input  logic              issue_valid,
  input  logic              issue_write,
  input  logic [ADDR_W-1:0] issue_dst,
  output logic              stall,
  output logic              sb_err
);
  import cpu_pkg::*;

  localparam int                NREG     = 2**ADDR_W;
  localparam logic [ADDR_W-1:0] ZERO_IDX = ADDR_W'(REG_ZERO);

  logic [DATA_W-1:0] regs_q [NREG];
  logic              commitFire;

  assign commitFire = wb_write && (wb_addr != ZERO_IDX);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NREG; i++) regs_q[i] <= '0;
    end else if (commitFire) begin
      regs_q[wb_addr] <= wb_data;
    end
  end

  // Same-cycle write-through gives zero commit-to-read latency.
  assign rd_data_a = (rd_addr_a == ZERO_IDX)                 ? '0      :
                     (wb_write && (wb_addr == rd_addr_a))    ? wb_data :
                                                               regs_q[rd_addr_a];
  assign rd_data_b = (rd_addr_b == ZERO_IDX)                 ? '0      :
                     (wb_write && (wb_addr == rd_addr_b))    ? wb_data :
                                                               regs_q[rd_addr_b];

  reg_scoreboard #(
    .ADDR_W (ADDR_W),
    .CNT_W  (CNT_W)
  ) u_scoreboard (
    .clk           (clk),
    .rst           (rst),
    .wb_write_i    (wb_write),
    .wb_addr_i     (wb_addr),
    .rd_addr_a_i   (rd_addr_a),
    .rd_addr_b_i   (rd_addr_b),
    .use_a_i       (use_a),
    .use_b_i       (use_b),
    .issue_valid_i (issue_valid),
    .issue_write_i (issue_write),
    .issue_dst_i   (issue_dst),
    .stall_o       (stall),
    .sb_err_o      (sb_err)
  );

endmodule

// File: tb/tb_wb_regfile.sv
// Directed self-checking bench for wb_regfile: reset, register zero, bypass,
// RAW stalls, counter saturation, simultaneous issue/commit and underflow.
module tb_wb_regfile;

  logic        clk;
  logic        rst;
  logic        wb_write;
  logic [4:0]  wb_addr;
  logic [31:0] wb_data;
  logic [4:0]  rd_addr_a, rd_addr_b;
  logic        use_a, use_b;
  logic [31:0] rd_data_a, rd_data_b;
  logic        issue_valid, issue_write;
  logic [4:0]  issue_dst;
  logic        stall, sb_err;

  int passCount  = 0;
  int checkCount = 0;

  wb_regfile #(.DATA_W(32), .ADDR_W(5), .CNT_W(2)) dut (
    .clk         (clk),
    .rst         (rst),
    .wb_write    (wb_write),
    .wb_addr     (wb_addr),
    .wb_data     (wb_data),
    .rd_addr_a   (rd_addr_a),
    .rd_addr_b   (rd_addr_b),
    .use_a       (use_a),
    .use_b       (use_b),
    .rd_data_a   (rd_data_a),
    .rd_data_b   (rd_data_b),
    .issue_valid (issue_valid),
    .issue_write (issue_write),
    .issue_dst   (issue_dst),
    .stall       (stall),
    .sb_err      (sb_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic idle();
    wb_write = 0; wb_addr = 0; wb_data = 0;
    rd_addr_a = 0; rd_addr_b = 0; use_a = 0; use_b = 0;
    issue_valid = 0; issue_write = 0; issue_dst = 0;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Pulses the asynchronous reset between clock edges.
  task automatic doReset();
    idle();
    rst = 1; #2;
    rst = 0; #1;
  endtask

  task automatic test_reset();
    idle();
    rst = 1; rd_addr_a = 5;
    #3;
    checkCount++; if (rd_data_a !== 32'h0) $display("[TB] FAIL reset_init_rd_a: got %h expected %h", rd_data_a, 32'h0); else passCount++;
    checkCount++; if (stall !== 1'b0) $display("[TB] FAIL reset_init_stall: got %b expected 0", stall); else passCount++;
    checkCount++; if (sb_err !== 1'b0) $display("[TB] FAIL reset_init_sb_err: got %b expected 0", sb_err); else passCount++;
    step();
    rst = 0;
    wb_write = 1; wb_addr = 5; wb_data = 32'h1234;
    step();
    wb_write = 0; wb_data = 0;
    issue_valid = 1; issue_write = 1; issue_dst = 6;
    step();
    issue_valid = 0; issue_write = 0;
    rd_addr_a = 5; rd_addr_b = 6; use_b = 1;
    #2;
    checkCount++; if (rd_data_a !== 32'h1234) $display("[TB] FAIL reg5_written: got %h expected %h", rd_data_a, 32'h1234); else passCount++;
    checkCount++; if (stall !== 1'b1) $display("[TB] FAIL pre_reset_stall: got %b expected 1", stall); else passCount++;
    rst = 1;
    #1;
    checkCount++; if (rd_data_a !== 32'h0) $display("[TB] FAIL midrun_reset_rd_a: got %h expected %h", rd_data_a, 32'h0); else passCount++;
    checkCount++; if (stall !== 1'b0) $display("[TB] FAIL midrun_reset_stall: got %b expected 0", stall); else passCount++;
    checkCount++; if (sb_err !== 1'b0) $display("[TB] FAIL midrun_reset_sb_err: got %b expected 0", sb_err); else passCount++;
    step();
    rst = 0;
    idle();
  endtask

  task automatic test_zero();
    idle();
    wb_write = 1; wb_addr = 0; wb_data = 32'hDEAD; rd_addr_a = 0; rd_addr_b = 0;
    #2;
    checkCount++; if (rd_data_a !== 32'h0) $display("[TB] FAIL zero_no_bypass: got %h expected %h", rd_data_a, 32'h0); else passCount++;
    step();
    wb_write = 0; wb_data = 0;
    #2;
    checkCount++; if (rd_data_b !== 32'h0) $display("[TB] FAIL zero_after_write: got %h expected %h", rd_data_b, 32'h0); else passCount++;
    issue_valid = 1; issue_write = 1; issue_dst = 0;
    step();
    issue_valid = 0; issue_write = 0;
    use_a = 1; rd_addr_a = 0;
    #2;
    checkCount++; if (stall !== 1'b0) $display("[TB] FAIL zero_never_busy: got %b expected 0", stall); else passCount++;
    step();
    idle();
  endtask

  task automatic test_bypass();
    idle();
    wb_write = 1; wb_addr = 7; wb_data = 32'hCAFEBABE; rd_addr_a = 7; rd_addr_b = 7;
    #2;
    checkCount++; if (rd_data_a !== 32'hCAFEBABE) $display("[TB] FAIL bypass_a: got %h expected %h", rd_data_a, 32'hCAFEBABE); else passCount++;
    checkCount++; if (rd_data_b !== 32'hCAFEBABE) $display("[TB] FAIL bypass_b: got %h expected %h", rd_data_b, 32'hCAFEBABE); else passCount++;
    step();
    wb_write = 0; wb_data = 32'h0;
    #2;
    checkCount++; if (rd_data_a !== 32'hCAFEBABE) $display("[TB] FAIL stored_a: got %h expected %h", rd_data_a, 32'hCAFEBABE); else passCount++;
    step();
    idle();
  endtask

  task automatic test_raw_stall();
    doReset();
    issue_valid = 1; issue_write = 1; issue_dst = 3;
    #2;
    checkCount++; if (stall !== 1'b0) $display("[TB] FAIL raw_issue_stall: got %b expected 0", stall); else passCount++;
    step();
    issue_valid = 0; issue_write = 0;
    use_a = 1; rd_addr_a = 3;
    #2;
    checkCount++; if (stall !== 1'b1) $display("[TB] FAIL raw_stall_set: got %b expected 1", stall); else passCount++;
    step();
    #2;
    checkCount++; if (stall !== 1'b1) $display("[TB] FAIL raw_stall_hold: got %b expected 1", stall); else passCount++;
    wb_write = 1; wb_addr = 3; wb_data = 32'h55;
    #2;
    checkCount++; if (stall !== 1'b0) $display("[TB] FAIL raw_commit_stall: got %b expected 0", stall); else passCount++;
    checkCount++; if (rd_data_a !== 32'h55) $display("[TB] FAIL raw_commit_data: got %h expected %h", rd_data_a, 32'h55); else passCount++;
    step();
    wb_write = 0; wb_data = 0;
    #2;
    checkCount++; if (stall !== 1'b0) $display("[TB] FAIL raw_after_stall: got %b expected 0", stall); else passCount++;
    checkCount++; if (rd_data_a !== 32'h55) $display("[TB] FAIL raw_after_data: got %h expected %h", rd_data_a, 32'h55); else passCount++;
    step();
    idle();
  endtask

  task automatic test_multi_inflight();
    doReset();
    issue_valid = 1; issue_write = 1; issue_dst = 9;
    step(); step(); step();
    #1;
    checkCount++; if (sb_err !== 1'b0) $display("[TB] FAIL multi_no_err_at_3: got %b expected 0", sb_err); else passCount++;
    step();
    issue_valid = 0; issue_write = 0;
    #1;
    checkCount++; if (sb_err !== 1'b1) $display("[TB] FAIL multi_overflow_err: got %b expected 1", sb_err); else passCount++;
    use_a = 1; rd_addr_a = 9;
    #1;
    checkCount++; if (stall !== 1'b1) $display("[TB] FAIL multi_busy: got %b expected 1", stall); else passCount++;
    for (int k = 1; k <= 3; k++) begin
      wb_write = 1; wb_addr = 9; wb_data = 32'(k);
      #2;
      checkCount++;
      if (stall !== (k == 3 ? 1'b0 : 1'b1))
        $display("[TB] FAIL multi_commit_%0d_stall: got %b expected %b", k, stall, (k == 3 ? 1'b0 : 1'b1));
      else passCount++;
      step();
    end
    wb_write = 0; wb_data = 0;
    #2;
    checkCount++; if (stall !== 1'b0) $display("[TB] FAIL multi_cleared: got %b expected 0", stall); else passCount++;
    checkCount++; if (rd_data_a !== 32'h3) $display("[TB] FAIL multi_last_data: got %h expected %h", rd_data_a, 32'h3); else passCount++;
    step();
    idle();
  endtask

  task automatic test_simul_incdec();
    doReset();
    issue_valid = 1; issue_write = 1; issue_dst = 4;
    step();
    wb_write = 1; wb_addr = 4; wb_data = 32'h44;
    step();
    idle();
    use_b = 1; rd_addr_b = 4;
    #2;
    checkCount++; if (stall !== 1'b1) $display("[TB] FAIL incdec_still_busy: got %b expected 1", stall); else passCount++;
    checkCount++; if (sb_err !== 1'b0) $display("[TB] FAIL incdec_sb_err: got %b expected 0", sb_err); else passCount++;
    checkCount++; if (rd_data_b !== 32'h44) $display("[TB] FAIL incdec_data: got %h expected %h", rd_data_b, 32'h44); else passCount++;
    wb_write = 1; wb_addr = 4; wb_data = 32'h45;
    step();
    wb_write = 0; wb_data = 0;
    #2;
    checkCount++; if (stall !== 1'b0) $display("[TB] FAIL incdec_cleared: got %b expected 0", stall); else passCount++;
    step();
    idle();
  endtask

  task automatic test_underflow();
    doReset();
    wb_write = 1; wb_addr = 12; wb_data = 32'h77;
    #2;
    checkCount++; if (sb_err !== 1'b0) $display("[TB] FAIL underflow_before_edge: got %b expected 0", sb_err); else passCount++;
    step();
    wb_write = 0; wb_data = 0; rd_addr_a = 12;
    #2;
    checkCount++; if (sb_err !== 1'b1) $display("[TB] FAIL underflow_err: got %b expected 1", sb_err); else passCount++;
    checkCount++; if (rd_data_a !== 32'h77) $display("[TB] FAIL underflow_data: got %h expected %h", rd_data_a, 32'h77); else passCount++;
    step(); step();
    checkCount++; if (sb_err !== 1'b1) $display("[TB] FAIL underflow_sticky: got %b expected 1", sb_err); else passCount++;
    idle();
  endtask

  task automatic test_stall_gated();
    doReset();
    issue_valid = 1; issue_write = 1; issue_dst = 3;
    step();
    issue_dst = 8; use_a = 1; rd_addr_a = 3;
    #2;
    checkCount++; if (stall !== 1'b1) $display("[TB] FAIL gated_stall: got %b expected 1", stall); else passCount++;
    step();
    idle();
    use_b = 1; rd_addr_b = 8;
    #2;
    checkCount++; if (stall !== 1'b0) $display("[TB] FAIL gated_not_counted: got %b expected 0", stall); else passCount++;
    checkCount++; if (sb_err !== 1'b0) $display("[TB] FAIL gated_sb_err: got %b expected 0", sb_err); else passCount++;
    use_b = 0; use_a = 1; rd_addr_a = 3;
    #1;
    checkCount++; if (stall !== 1'b1) $display("[TB] FAIL gated_first_kept: got %b expected 1", stall); else passCount++;
    step();
    idle();
  endtask

  initial begin
    rst = 1;
    idle();
    test_reset();
    test_zero();
    test_bypass();
    test_raw_stall();
    test_multi_inflight();
    test_simul_incdec();
    test_underflow();
    test_stall_gated();
    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule

// File: doc/wb_regfile.md
Name: wb_regfile

Overview:
- Receiving end of the write-back interface: consumes wb_write/wb_addr/wb_data from the WB pipeline segment and commits them into the 32-entry general-purpose register file.
- Serves two combinational read ports to the ID stage, with same-cycle write-through bypass.
- Contains a per-register pending-write scoreboard: ID issues mark destinations pending, WB commits retire them, and a stall is raised for reads of pending registers.

Parameters:
- DATA_W, 32, register width
- ADDR_W, 5, register index width (2**ADDR_W registers)
- CNT_W, 2, pending-write counter width per register; max in-flight writes per register = 2**CNT_W-1

Ports:
- clk  in  1  clock; all state updates on posedge
- rst  in  1  reset, asynchronous, active-high
- wb_write  in  1  commit enable from WB segment
- wb_addr  in  ADDR_W  commit destination
- wb_data  in  DATA_W  commit value
- rd_addr_a  in  ADDR_W  read port A index (rs)
- rd_addr_b  in  ADDR_W  read port B index (rt)
- use_a  in  1  ID instruction actually consumes port A
- use_b  in  1  ID instruction actually consumes port B
- rd_data_a  out  DATA_W  port A value
- rd_data_b  out  DATA_W  port B value
- issue_valid  in  1  ID instruction leaves ID this cycle
- issue_write  in  1  that instruction writes a register
- issue_dst  in  ADDR_W  its destination index
- stall  out  1  hold ID; operand pending
- sb_err  out  1  sticky scoreboard overflow/underflow flag

Behaviour:
- Reset (async, any time, including mid-operation): all registers = 0, all counters = 0, sb_err = 0. Outputs follow combinationally: rd_data_* = 0, stall = 0.
- Register 0 is hardwired to zero:
  - Writes to index 0 are dropped.
  - Reads of index 0 return 0 and are never busy.
  - Issues to index 0 are not counted.
- Commit: at posedge, if wb_write && wb_addr != 0, then reg[wb_addr] <= wb_data. The WB segment drives these signals from negedge-latched state, so they are stable by posedge.
- Read, combinational: rd_data_x = 0 if addr == 0; else wb_data if (wb_write && wb_addr == addr); else reg[addr]. Commit-to-read latency is therefore 0 cycles.
- Pending counters cnt[i], updated at posedge:
  - inc = issue_valid && !stall && issue_write && issue_dst != 0 && issue_dst == i
  - dec = wb_write && wb_addr != 0 && wb_addr == i
  - inc && dec: cnt unchanged.
  - inc only: if cnt == max, cnt stays at max and sb_err <= 1; else cnt + 1.
  - dec only: if cnt == 0, cnt stays 0 and sb_err <= 1; else cnt - 1.
- busy_x (internal) = addr != 0 && (cnt[addr] - (dec on addr this cycle ? 1 : 0)) != 0. A retiring last write is bypassed and therefore not busy.
- stall = (use_a && busy_a) || (use_b && busy_b), combinational.
- An issue while stall = 1 is ignored by the scoreboard. The issuer must re-present the instruction.
- sb_err clears only on rst.
- Both read ports may address the same register; each port resolves independently.

Decomposition:
- Shared package cpu_pkg: DATA_W, ADDR_W, REG_ZERO = 0, and the reg-index typedef used by the ID/EX/MEM/WB segments.
- One sub-module, reg_scoreboard: the counter array, busy lookup for two ports, and sb_err.
- Storage array and bypass mux stay in wb_regfile.

Test Plan:
- Reset/zero: assert rst mid-run after writing reg5 = 0x1234 → rd_data_a(5) = 0, stall = 0, sb_err = 0. Then wb_write to addr 0 with 0xDEAD → read of 0 returns 0.
- Commit+bypass: wb_write = 1, wb_addr = 7, wb_data = 0xCAFEBABE, rd_addr_a = 7 in the same cycle → rd_data_a = 0xCAFEBABE before posedge. After posedge with wb_write = 0 it is still 0xCAFEBABE.
- RAW stall: issue dst = 3; next cycle use_a = 1, rd_addr_a = 3 → stall = 1. Hold until wb_write addr 3 = 0x55 → stall = 0 in that same cycle, rd_data_a = 0x55.
- Multiple in flight: issue dst = 9 three consecutive cycles → cnt = 3. A fourth issue → sb_err = 1, cnt stays 3. Three commits to 9 → busy clears only after the third.
- Simultaneous inc/dec: cnt[4] = 1, issue dst = 4 and wb_write addr = 4 in the same cycle → cnt[4] = 1 after posedge, stall for rd_addr_b = 4 with use_b = 1 remains 1.
- Underflow/stall-gated issue: wb_write addr 12 with cnt = 0 → sb_err = 1. issue_valid while stall = 1 → counter unchanged.
